note_detector: RTL and testbench

// Receive side of the melody player: measures the period of an incoming square-wave tone and decodes it into the same
// 4-bit note code used to index the player's note bus (0 do2, 1 do3, 2 fa2, 3 la1, 4 la2, 5 mi2, 6 re2, 7 reb2,
// 8 reb3, 9 sib2, 10 sol2, 11 mute, 12 re1, 13 re3, 14 unknown). Sits between a board tone input and the

---
 rtl/note_detector.sv | 155 +++++++++++++++
 tb/tb_note_detector.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/note_detector.sv
// Tone period meter: measures rising-edge-to-rising-edge period of tone_in and
// decodes it into the melody player's 4-bit note code with a stability filter.
module note_detector #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TOL_SHIFT   = 6,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [3:0]  note_code,
  output logic        note_change,
  output logic [19:0] period,
  output logic        locked
);

  // state   | meaning
  // S_MUTE  | no tone; next rise only restarts the period counter
  // S_ARM   | one rise seen; next rise yields the first valid period
  // S_TRACK | periods are being measured and classified
  typedef enum logic [1:0] {S_MUTE, S_ARM, S_TRACK} state_t;

  localparam logic [3:0] CODE_MUTE = 4'd11;
  localparam logic [3:0] CODE_UNK  = 4'd14;
  localparam int CNT_W = (STABLE_CNT < 3) ? 2 : $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
  localparam logic [19:0] TIMEOUT = 20'(TIMEOUT_CYC);
  localparam longint unsigned CLK100 = 64'(CLK_HZ) * 64'd100;

  // Indexed by note code; entry 11 (mute) is never matched.
  localparam logic [19:0] P_TAB [14] = '{
    20'(CLK100 / 64'd26163), 20'(CLK100 / 64'd52325), 20'(CLK100 / 64'd34923),
    20'(CLK100 / 64'd22000), 20'(CLK100 / 64'd44000), 20'(CLK100 / 64'd32963),
    20'(CLK100 / 64'd29366), 20'(CLK100 / 64'd27718), 20'(CLK100 / 64'd55437),
    20'(CLK100 / 64'd46616), 20'(CLK100 / 64'd39200), 20'd0,
    20'(CLK100 / 64'd14683), 20'(CLK100 / 64'd58733)
  };

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic [19:0]      cnt_q, cnt_d;
  logic [19:0]      period_q, period_d;
  logic             cls_vld_q, cls_vld_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [3:0]       code_q, code_d;
  logic             change_q, change_d;

  logic [3:0]  cls;
  logic [19:0] diff;
  logic        timeout;

  always_comb begin
    cls  = CODE_UNK;
    diff = '0;
    for (int k = 0; k < 14; k++) begin
      if (k != 11) begin
        diff = (period_q >= P_TAB[k]) ? (period_q - P_TAB[k]) : (P_TAB[k] - period_q);
        if (diff <= (P_TAB[k] >> TOL_SHIFT)) cls = 4'(k);
      end
    end
  end

  always_comb begin
    sync1_d   = tone_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    rise_d    = sync2_q & ~prev_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    cls_vld_d = 1'b0;
    cand_d    = cand_q;
    mcnt_d    = mcnt_q;
    code_d    = code_q;
    change_d  = 1'b0;
    timeout   = (cnt_q == TIMEOUT);

    if (rise_q)        cnt_d = 20'd1;
    else if (!timeout) cnt_d = cnt_q + 20'd1;

    case (state_q)
      S_MUTE: begin
        if (rise_q) state_d = S_ARM;
      end
      S_ARM, S_TRACK: begin
        // A rise coinciding with timeout is still measured (period = TIMEOUT).
        if (rise_q) begin
          period_d  = cnt_q;
          cls_vld_d = 1'b1;
          state_d   = S_TRACK;
        end else if (timeout) begin
          state_d  = S_MUTE;
          code_d   = CODE_MUTE;
          change_d = (code_q != CODE_MUTE);
          mcnt_d   = '0;
        end
      end
      default: state_d = S_MUTE;
    endcase

    if (cls_vld_q) begin
      if (cls == cand_q) begin
        if (mcnt_q != STABLE_V) mcnt_d = mcnt_q + CNT_W'(1);
      end else begin
        cand_d = cls;
        mcnt_d = CNT_W'(1);
      end
      if ((mcnt_d == STABLE_V) && (cand_d != code_q)) begin
        code_d   = cand_d;
        change_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_MUTE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      cls_vld_q <= 1'b0;
      cand_q    <= '0;
      mcnt_q    <= '0;
      code_q    <= CODE_MUTE;
      change_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      rise_q    <= rise_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      cls_vld_q <= cls_vld_d;
      cand_q    <= cand_d;
      mcnt_q    <= mcnt_d;
      code_q    <= code_d;
      change_q  <= change_d;
    end
  end

  assign note_code   = code_q;
  assign note_change = change_q;
  assign period      = period_q;
  assign locked      = (state_q == S_TRACK) && (code_q != CODE_MUTE) && (code_q != CODE_UNK);

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at CLK_HZ = 1 MHz so note periods stay short:
// la2 = 2272 (tol 35), re3 = 1702, do3 = 1911; timeout shortened to 5000 cycles.
module tb_note_detector;

  localparam int T_OUT = 5000;
  localparam int HW    = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic [3:0]  note_code;
  logic        note_change;
  logic [19:0] period;
  logic        locked;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int chg_cnt = 0;
  int last_rise_cyc = 0;

  note_detector #(
    .CLK_HZ(1_000_000), .TOL_SHIFT(6), .STABLE_CNT(3), .TIMEOUT_CYC(T_OUT)
  ) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in),
    .note_code(note_code), .note_change(note_change), .period(period), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (note_change === 1'b1) chg_cnt++;
  end

  typedef struct {
    int per;
    int reps;
    int code;
    int lck;
    int chg;
    int prd;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge with tone low, HW cycles after the previous rise;
  // produces the next rise exactly n cycles after the previous one.
  task automatic rise_after(input int n);
    repeat (n - HW) @(negedge clk);
    tone_in = 1'b1;
    last_rise_cyc = cyc;
    repeat (HW) @(negedge clk);
    tone_in = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int code, input int lck, input int prd);
    check({tag, " code"}, int'(note_code), code);
    check({tag, " locked"}, int'(locked), lck);
    check({tag, " period"}, int'(period), prd);
  endtask

  initial begin
    int c0;
    int target;

    vecs[0] = '{2272, 3, 4, 1, 1, 2272};   // lock la2
    vecs[1] = '{1702, 1, 4, 1, 0, 1702};   // single re3 glitch
    vecs[2] = '{2272, 2, 4, 1, 0, 2272};
    vecs[3] = '{1702, 3, 13, 1, 1, 1702};  // switch to re3
    vecs[4] = '{2237, 3, 4, 1, 1, 2237};   // la2 lower bound
    vecs[5] = '{2308, 3, 14, 0, 1, 2308};  // just past upper bound
    vecs[6] = '{2307, 3, 4, 1, 1, 2307};   // la2 upper bound
    vecs[7] = '{1911, 2, 4, 1, 0, 1911};   // two do3 periods: not yet stable
    vecs[8] = '{1911, 1, 1, 1, 1, 1911};
    vecs[9] = '{2272, 3, 4, 1, 1, 2272};

    repeat (3) @(negedge clk);
    check_outs("reset", 11, 0, 0);
    check("reset change", int'(note_change), 0);
    rst = 1'b0;

    rise_after(500);
    check_outs("arm", 11, 0, 0);
    check("arm change", chg_cnt, 0);

    for (int i = 0; i < 10; i++) begin
      c0 = chg_cnt;
      for (int r = 0; r < vecs[i].reps; r++) rise_after(vecs[i].per);
      check_outs($sformatf("v%0d", i), vecs[i].code, vecs[i].lck, vecs[i].prd);
      check($sformatf("v%0d strobes", i), chg_cnt - c0, vecs[i].chg);
    end

    // Timeout: code 11 becomes visible TIMEOUT + 4 cycles after the tone rise
    // (3 sync/edge cycles + counter load, then TIMEOUT counts).
    c0 = chg_cnt;
    target = last_rise_cyc + T_OUT + 3;
    while (cyc < target) @(negedge clk);
    check("to before code", int'(note_code), 4);
    @(negedge clk);
    check("to code", int'(note_code), 11);
    check("to strobe", int'(note_change), 1);
    check("to locked", int'(locked), 0);
    repeat (5) @(negedge clk);
    check("to strobes", chg_cnt - c0, 1);
    check("to period", int'(period), 2272);

    // Relock, then reset mid-lock.
    rise_after(700);
    check("mute arm code", int'(note_code), 11);
    for (int r = 0; r < 3; r++) rise_after(2272);
    check_outs("relock", 4, 1, 2272);

    #3 rst = 1'b1;
    #1;
    check_outs("async rst", 11, 0, 0);
    check("async rst change", int'(note_change), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    c0 = chg_cnt;
    rise_after(2272);
    check_outs("post rst arm", 11, 0, 0);
    rise_after(2272);
    rise_after(2272);
    check_outs("post rst 2p", 11, 0, 2272);
    check("post rst 2p strobes", chg_cnt - c0, 0);
    rise_after(2272);
    check_outs("post rst lock", 4, 1, 2272);
    check("post rst strobes", chg_cnt - c0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
